// File: rtl/z_env_gen.sv
// -----------------------------------------------------------------------------
// z_env_gen -- "breathing" envelope generator for a downstream PWM.
//
// The duty word ramps up from 0 to pPERIOD in pDELTA increments, dwells at
// full scale for hold_hi steps, ramps back down to 0, dwells at zero for
// hold_lo steps, then starts the next cycle. A "step" is every pSTEP_PRD-th
// end_tick pulse from the PWM, so the ramp stays locked to PWM periods.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   en          in   enable; low forces IDLE with zero duty on the next edge
//   end_tick    in   one-cycle pulse at the end of each PWM period
//   hold_hi     in   [7:0] dwell steps at full scale (sampled on HOLD_HI entry)
//   hold_lo     in   [7:0] dwell steps at zero (sampled on HOLD_LO entry)
//   cyc_duty    out  [pWIDTH-1:0] registered duty word
//   phase       out  [2:0] current state (IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4)
//   cycle_done  out  one-cycle pulse when a full breathing cycle completes
// -----------------------------------------------------------------------------
module z_env_gen #(
   parameter int pWIDTH    = 20,
   parameter int pPERIOD   = 1000000,
   parameter int pDELTA    = 5000,
   parameter int pSTEP_PRD = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              end_tick,
   input  logic [7:0]        hold_hi,
   input  logic [7:0]        hold_lo,
   output logic [pWIDTH-1:0] cyc_duty,
   output logic [2:0]        phase,
   output logic              cycle_done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RISE    = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_FALL    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

   localparam int lpSTEP_W = $clog2(pSTEP_PRD + 1);

   localparam logic [lpSTEP_W-1:0] lpSTEP_MAX = lpSTEP_W'(pSTEP_PRD);
   localparam logic [lpSTEP_W-1:0] lpSTEP_ONE = lpSTEP_W'(1);
   // One extra bit so the rising sum can exceed pPERIOD without wrapping.
   localparam logic [pWIDTH:0]     lpPERIOD_X = (pWIDTH + 1)'(pPERIOD);
   localparam logic [pWIDTH:0]     lpDELTA_X  = (pWIDTH + 1)'(pDELTA);

   state_t              r_state;
   logic [pWIDTH-1:0]   r_duty;
   logic [lpSTEP_W-1:0] r_step_cnt;
   logic [7:0]          r_dwell;
   logic                r_cycle_done;

   state_t              w_state_nxt;
   logic [pWIDTH-1:0]   w_duty_nxt;
   logic [lpSTEP_W-1:0] w_step_nxt;
   logic [7:0]          w_dwell_nxt;
   logic                w_done_nxt;

   logic                w_is_step;
   logic [pWIDTH:0]     w_duty_sum;
   logic [pWIDTH-1:0]   w_duty_up;
   logic [pWIDTH-1:0]   w_duty_dn;
   logic                w_dwell_last;

   // The step is the end_tick that finds the counter already at pSTEP_PRD.
   assign w_is_step    = end_tick && (r_state != ST_IDLE) && (r_step_cnt == lpSTEP_MAX);

   // Saturating ramp arithmetic: clamp to pPERIOD going up, to 0 going down.
   assign w_duty_sum   = {1'b0, r_duty} + lpDELTA_X;
   assign w_duty_up    = (w_duty_sum > lpPERIOD_X) ? lpPERIOD_X[pWIDTH-1:0]
                                                   : w_duty_sum[pWIDTH-1:0];
   assign w_duty_dn    = ({1'b0, r_duty} > lpDELTA_X) ? (r_duty - lpDELTA_X[pWIDTH-1:0])
                                                      : '0;

   // Dwell ends on the step that takes the counter from 1 to 0.
   assign w_dwell_last = (r_dwell <= 8'd1);

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every target gets a default first, so no path leaves a value
      // unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_step_nxt  = r_step_cnt;
      w_dwell_nxt = r_dwell;
      w_done_nxt  = 1'b0;

      if (!en) begin
         // Disable beats any simultaneous step: abandon the envelope.
         w_state_nxt = ST_IDLE;
         w_duty_nxt  = '0;
         w_step_nxt  = '0;
         w_dwell_nxt = '0;
      end else begin
         // Ticks counted 1..pSTEP_PRD in every active state; IDLE ignores them.
         if (r_state != ST_IDLE && end_tick) begin
            w_step_nxt = w_is_step ? lpSTEP_ONE : (r_step_cnt + lpSTEP_ONE);
         end

         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_RISE;
               w_duty_nxt  = '0;
               w_step_nxt  = lpSTEP_ONE;
            end

            ST_RISE: begin
               if (w_is_step) begin
                  w_duty_nxt = w_duty_up;
                  if ({1'b0, w_duty_up} == lpPERIOD_X) begin
                     if (hold_hi == 8'd0) begin
                        w_state_nxt = ST_FALL;
                     end else begin
                        w_state_nxt = ST_HOLD_HI;
                        w_dwell_nxt = hold_hi;
                     end
                  end
               end
            end

            ST_HOLD_HI: begin
               if (w_is_step) begin
                  w_dwell_nxt = r_dwell - 8'd1;
                  if (w_dwell_last) begin
                     w_dwell_nxt = '0;
                     w_state_nxt = ST_FALL;
                  end
               end
            end

            ST_FALL: begin
               if (w_is_step) begin
                  w_duty_nxt = w_duty_dn;
                  if (w_duty_dn == '0) begin
                     if (hold_lo == 8'd0) begin
                        w_state_nxt = ST_RISE;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_state_nxt = ST_HOLD_LO;
                        w_dwell_nxt = hold_lo;
                     end
                  end
               end
            end

            ST_HOLD_LO: begin
               if (w_is_step) begin
                  w_dwell_nxt = r_dwell - 8'd1;
                  if (w_dwell_last) begin
                     w_dwell_nxt = '0;
                     w_state_nxt = ST_RISE;
                     w_done_nxt  = 1'b1;
                  end
               end
            end

            default: begin
               // Unreachable encodings recover to a clean IDLE.
               w_state_nxt = ST_IDLE;
               w_duty_nxt  = '0;
               w_step_nxt  = '0;
               w_dwell_nxt = '0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         r_state      <= ST_IDLE;
         r_duty       <= '0;
         r_step_cnt   <= lpSTEP_ONE;
         r_dwell      <= '0;
         r_cycle_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_duty       <= w_duty_nxt;
         r_step_cnt   <= w_step_nxt;
         r_dwell      <= w_dwell_nxt;
         r_cycle_done <= w_done_nxt;
      end
   end

   assign cyc_duty   = r_duty;
   assign phase      = r_state;
   assign cycle_done = r_cycle_done;

endmodule
